// File: rtl/nvdla_pdp_pkg.sv
// Shared PDP scheduler types: FSM state encoding, split-position codes, atom shift default.
package nvdla_pdp_pkg;
  localparam int PDP_ATOM_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_SPLIT_END,
    ST_DONE
  } pdp_state_e;

  localparam logic [1:0] SPLIT_POS_ONLY  = 2'd0;
  localparam logic [1:0] SPLIT_POS_FIRST = 2'd1;
  localparam logic [1:0] SPLIT_POS_MID   = 2'd2;
  localparam logic [1:0] SPLIT_POS_LAST  = 2'd3;

  function automatic logic [1:0] f_split_pos(input logic [7:0] idx, input logic [7:0] num);
    if (num == 8'd0)      return SPLIT_POS_ONLY;
    else if (idx == 8'd0) return SPLIT_POS_FIRST;
    else if (idx == num)  return SPLIT_POS_LAST;
    else                  return SPLIT_POS_MID;
  endfunction
endpackage

// File: rtl/nvdla_pdp_split_beat_cnt.sv
// Nested width/height/surface beat counters for one split; flags the split's final beat.
module nvdla_pdp_split_beat_cnt (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        i_clr,
  input  logic        i_beat,
  input  logic [9:0]  i_w_max,
  input  logic [12:0] i_h_max,
  input  logic [12:0] i_s_max,
  output logic        split_last_beat
);
  logic [9:0]  r_w_cnt;
  logic [12:0] r_h_cnt;
  logic [12:0] r_s_cnt;
  logic        w_w_end, w_h_end, w_s_end;

  assign w_w_end = (r_w_cnt == i_w_max);
  assign w_h_end = (r_h_cnt == i_h_max);
  assign w_s_end = (r_s_cnt == i_s_max);
  assign split_last_beat = i_beat & w_w_end & w_h_end & w_s_end;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_w_cnt <= '0;
      r_h_cnt <= '0;
      r_s_cnt <= '0;
    end else if (i_clr) begin
      r_w_cnt <= '0;
      r_h_cnt <= '0;
      r_s_cnt <= '0;
    end else if (i_beat) begin
      // Carry ripples inward-out; all three wrap together on the split's last beat.
      if (!w_w_end) r_w_cnt <= r_w_cnt + 10'd1;
      else begin
        r_w_cnt <= '0;
        if (!w_h_end) r_h_cnt <= r_h_cnt + 13'd1;
        else begin
          r_h_cnt <= '0;
          r_s_cnt <= w_s_end ? 13'd0 : r_s_cnt + 13'd1;
        end
      end
    end
  end
endmodule

// File: rtl/nvdla_pdp_split_sched.sv
// PDP per-operation split scheduler: start detect, split walk, done pulse.
// Optional stall counter enabled by NVDLA_PDP_SPLIT_SCHED_PERF_EN.
module nvdla_pdp_split_sched
  import nvdla_pdp_pkg::*;
#(
  parameter int ATOM_SHIFT = PDP_ATOM_SHIFT
`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        reg2dp_op_en,
  input  logic [7:0]  pooling_splitw_num_cfg,
  input  logic [12:0] reg2dp_cube_in_width,
  input  logic [12:0] reg2dp_cube_out_width,
  input  logic [12:0] reg2dp_cube_out_height,
  input  logic [12:0] reg2dp_cube_in_channel,
  input  logic [9:0]  pooling_fwidth_cfg,
  input  logic [9:0]  pooling_mwidth_cfg,
  input  logic [9:0]  pooling_lwidth_cfg,
  input  logic [9:0]  pooling_out_fwidth_cfg,
  input  logic [9:0]  pooling_out_mwidth_cfg,
  input  logic [9:0]  pooling_out_lwidth_cfg,
  input  logic        pdp_dp2wdma_valid,
  input  logic        pdp_dp2wdma_ready,
  output logic        pdp_op_start,
  output logic [7:0]  split_idx,
  output logic [1:0]  split_pos,
  output logic [9:0]  split_in_width,
  output logic [9:0]  split_out_width,
  output logic        sched_busy,
  output logic        dp2reg_done
`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
  , output logic [CNT_W-1:0] dp2reg_stall_cnt
`endif
);
  pdp_state_e  r_state, w_state_n;
  logic        r_op_en_d, r_start, r_done, r_busy;
  logic [7:0]  r_idx, r_num;
  logic [1:0]  r_pos;
  logic [9:0]  r_inw, r_outw;
  logic [9:0]  r_cin_w, r_cout_w, r_fw, r_mw, r_lw, r_ofw, r_omw, r_olw;
  logic [12:0] r_out_h, r_s_max;
  logic        w_load, w_adv, w_beat, w_last_beat, w_unused;
  logic [7:0]  w_idx_n, w_num_n;
  logic [1:0]  w_pos_n;
  logic [9:0]  w_inw_n, w_outw_n;

  // Upper width bits never reach the 10-bit split datapath.
  assign w_unused = ^{reg2dp_cube_in_width[12:10], reg2dp_cube_out_width[12:10]};

  assign w_load = (r_state == ST_IDLE) & reg2dp_op_en & ~r_op_en_d;
  assign w_adv  = w_load | (r_state == ST_SPLIT_END);
  assign w_beat = pdp_dp2wdma_valid & pdp_dp2wdma_ready & (r_state == ST_RUN);

  // Split widths come from live inputs on the start edge, latched copies afterwards.
  always_comb begin
    w_num_n  = w_load ? pooling_splitw_num_cfg : r_num;
    w_idx_n  = w_load ? 8'd0 : r_idx + 8'd1;
    w_pos_n  = f_split_pos(w_idx_n, w_num_n);
    w_inw_n  = '0;
    w_outw_n = '0;
    case (w_pos_n)
      SPLIT_POS_ONLY: begin
        w_inw_n  = w_load ? reg2dp_cube_in_width[9:0]  : r_cin_w;
        w_outw_n = w_load ? reg2dp_cube_out_width[9:0] : r_cout_w;
      end
      SPLIT_POS_FIRST: begin
        w_inw_n  = w_load ? pooling_fwidth_cfg     : r_fw;
        w_outw_n = w_load ? pooling_out_fwidth_cfg : r_ofw;
      end
      SPLIT_POS_MID: begin
        w_inw_n  = w_load ? pooling_mwidth_cfg     : r_mw;
        w_outw_n = w_load ? pooling_out_mwidth_cfg : r_omw;
      end
      default: begin
        w_inw_n  = w_load ? pooling_lwidth_cfg     : r_lw;
        w_outw_n = w_load ? pooling_out_lwidth_cfg : r_olw;
      end
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:      if (w_load) w_state_n = ST_START;
      ST_START:     w_state_n = ST_RUN;
      ST_RUN:       if (w_last_beat) w_state_n = (r_idx == r_num) ? ST_DONE : ST_SPLIT_END;
      ST_SPLIT_END: w_state_n = ST_RUN;
      ST_DONE:      w_state_n = ST_IDLE;
      default:      w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state   <= ST_IDLE;
      r_op_en_d <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_idx     <= '0;
      r_pos     <= '0;
      r_inw     <= '0;
      r_outw    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_op_en_d <= reg2dp_op_en;
      r_start   <= (w_state_n == ST_START);
      r_done    <= (w_state_n == ST_DONE);
      r_busy    <= (w_state_n != ST_IDLE);
      if (r_state == ST_DONE) r_idx <= '0;
      else if (w_adv) begin
        r_idx  <= w_idx_n;
        r_pos  <= w_pos_n;
        r_inw  <= w_inw_n;
        r_outw <= w_outw_n;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_num <= '0; r_cin_w <= '0; r_cout_w <= '0; r_out_h <= '0; r_s_max <= '0;
      r_fw  <= '0; r_mw    <= '0; r_lw     <= '0;
      r_ofw <= '0; r_omw   <= '0; r_olw    <= '0;
    end else if (w_load) begin
      r_num    <= pooling_splitw_num_cfg;
      r_cin_w  <= reg2dp_cube_in_width[9:0];
      r_cout_w <= reg2dp_cube_out_width[9:0];
      r_out_h  <= reg2dp_cube_out_height;
      r_s_max  <= reg2dp_cube_in_channel >> ATOM_SHIFT;
      r_fw     <= pooling_fwidth_cfg;
      r_mw     <= pooling_mwidth_cfg;
      r_lw     <= pooling_lwidth_cfg;
      r_ofw    <= pooling_out_fwidth_cfg;
      r_omw    <= pooling_out_mwidth_cfg;
      r_olw    <= pooling_out_lwidth_cfg;
    end
  end

  nvdla_pdp_split_beat_cnt u_beat_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .i_clr           (r_state == ST_START),
    .i_beat          (w_beat),
    .i_w_max         (r_outw),
    .i_h_max         (r_out_h),
    .i_s_max         (r_s_max),
    .split_last_beat (w_last_beat)
  );

`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
  logic [CNT_W-1:0] r_stall;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_stall <= '0;
    else if (r_state == ST_START) r_stall <= '0;
    else if ((r_state == ST_RUN) & pdp_dp2wdma_valid & ~pdp_dp2wdma_ready & ~&r_stall)
      r_stall <= r_stall + 1'b1;
  end
  assign dp2reg_stall_cnt = r_stall;
`endif

  assign pdp_op_start    = r_start;
  assign dp2reg_done     = r_done;
  assign sched_busy      = r_busy;
  assign split_idx       = r_idx;
  assign split_pos       = r_pos;
  assign split_in_width  = r_inw;
  assign split_out_width = r_outw;
endmodule

// File: tb/tb_nvdla_pdp_split_sched.sv
// Directed bench for nvdla_pdp_split_sched; stall checks when NVDLA_PDP_SPLIT_SCHED_PERF_EN is set.
module tb_nvdla_pdp_split_sched;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        op_en = 1'b0;
  logic [7:0]  num;
  logic [12:0] in_w, out_w, out_h, ch;
  logic [9:0]  fw, mw, lw, ofw, omw, olw;
  logic        vld = 1'b0, rdy = 1'b1;
  logic        op_start, busy, done;
  logic [7:0]  idx;
  logic [1:0]  pos;
  logic [9:0]  s_inw, s_outw;
`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0, failures = 0;
  int n_start = 0, n_done = 0;

  always #5 clk = ~clk;

  nvdla_pdp_split_sched dut (
    .nvdla_core_clk         (clk),
    .nvdla_core_rstn        (rstn),
    .reg2dp_op_en           (op_en),
    .pooling_splitw_num_cfg (num),
    .reg2dp_cube_in_width   (in_w),
    .reg2dp_cube_out_width  (out_w),
    .reg2dp_cube_out_height (out_h),
    .reg2dp_cube_in_channel (ch),
    .pooling_fwidth_cfg     (fw),
    .pooling_mwidth_cfg     (mw),
    .pooling_lwidth_cfg     (lw),
    .pooling_out_fwidth_cfg (ofw),
    .pooling_out_mwidth_cfg (omw),
    .pooling_out_lwidth_cfg (olw),
    .pdp_dp2wdma_valid      (vld),
    .pdp_dp2wdma_ready      (rdy),
    .pdp_op_start           (op_start),
    .split_idx              (idx),
    .split_pos              (pos),
    .split_in_width         (s_inw),
    .split_out_width        (s_outw),
    .sched_busy             (busy),
    .dp2reg_done            (done)
`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
    , .dp2reg_stall_cnt     (stall_cnt)
`endif
  );

  always @(negedge clk) begin
    if (op_start) n_start++;
    if (done)     n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic cfg1();
    num = 8'd0; in_w = 13'd5; out_w = 13'd1; out_h = 13'd0; ch = 13'd7;
    fw = 10'd9; mw = 10'd9; lw = 10'd9; ofw = 10'd9; omw = 10'd9; olw = 10'd9;
  endtask

  task automatic cfg2();
    num = 8'd2; in_w = 13'd20; out_w = 13'd8; out_h = 13'd1; ch = 13'd15;
    fw = 10'd7; mw = 10'd5; lw = 10'd2; ofw = 10'd3; omw = 10'd1; olw = 10'd0;
  endtask

  // Plays the core: delivers exactly bt[k] accepted beats per split and checks split boundaries.
  task automatic run_op(input string nm, input int ns, input int bt[3], input int ps[3],
                        input int iw[3], input int ow[3], input bit rnd, input bit repulse,
                        input bit mess, input int abort_k, input int abort_b);
    int stalls = 0, d0 = n_done, s0 = n_start, guard = 0, got;
    bit bad;
    op_en = 1'b0;
    @(negedge clk); op_en = 1'b1;
    @(negedge clk);
    chk({nm, "_start"}, op_start, 1);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_idx0"}, idx, 0);
    chk({nm, "_pos0"}, pos, ps[0]);
    chk({nm, "_inw0"}, s_inw, iw[0]);
    chk({nm, "_outw0"}, s_outw, ow[0]);
    @(negedge clk);
    for (int k = 0; k < ns; k++) begin
      bad = 1'b0; got = 0;
      while (got < bt[k]) begin
        if (k == abort_k && got == abort_b) begin vld = 1'b0; return; end
        if (guard++ > 2000) begin chk({nm, "_timeout"}, 1, 0); vld = 1'b0; return; end
        if (idx != k[7:0] || done) bad = 1'b1;
        vld = 1'b1;
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (repulse && k == 0 && got == 1) op_en = 1'b0;
        if (repulse && k == 0 && got == 2) op_en = 1'b1;
        if (mess && k == 0 && got == 1) begin
          num = 8'd0; out_h = 13'd5; ch = 13'd63; fw = 10'd1; mw = 10'd1; lw = 10'd1;
          ofw = 10'd9; omw = 10'd9; olw = 10'd9; out_w = 13'd0;
        end
        @(posedge clk);
        if (rdy) got++; else stalls++;
        @(negedge clk);
      end
      vld = 1'b0; rdy = 1'b1;
      chk($sformatf("%s_beats%0d", nm, k), bad, 0);
      if (k < ns - 1) begin
        chk($sformatf("%s_bubble_idx%0d", nm, k), idx, k);
        chk($sformatf("%s_bubble_done%0d", nm, k), done, 0);
        @(negedge clk);
        chk($sformatf("%s_idx%0d", nm, k + 1), idx, k + 1);
        chk($sformatf("%s_pos%0d", nm, k + 1), pos, ps[k + 1]);
        chk($sformatf("%s_inw%0d", nm, k + 1), s_inw, iw[k + 1]);
        chk($sformatf("%s_outw%0d", nm, k + 1), s_outw, ow[k + 1]);
      end else begin
        chk({nm, "_done"}, done, 1);
        chk({nm, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({nm, "_done_clr"}, done, 0);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_idx_clr"}, idx, 0);
      end
    end
    repeat (2) @(negedge clk);
    chk({nm, "_one_done"}, n_done - d0, 1);
    chk({nm, "_one_start"}, n_start - s0, 1);
`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
    chk({nm, "_stall"}, stall_cnt, stalls);
`endif
  endtask

  initial begin
    cfg1();
    repeat (3) @(negedge clk);
    chk("rst_start", op_start, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", idx, 0);
    chk("rst_pos", pos, 0);
    chk("rst_widths", {s_inw, s_outw}, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_op("only", 1, '{2, 0, 0}, '{0, 0, 0}, '{5, 0, 0}, '{1, 0, 0}, 0, 0, 0, -1, 0);
    cfg2();
    run_op("split", 3, '{16, 8, 4}, '{1, 2, 3}, '{7, 5, 2}, '{3, 1, 0}, 0, 0, 0, -1, 0);
    run_op("rnd", 3, '{16, 8, 4}, '{1, 2, 3}, '{7, 5, 2}, '{3, 1, 0}, 1, 0, 0, -1, 0);
    run_op("repulse", 3, '{16, 8, 4}, '{1, 2, 3}, '{7, 5, 2}, '{3, 1, 0}, 0, 1, 0, -1, 0);
    repeat (4) @(negedge clk);
    chk("repulse_no_restart", busy, 0);
    chk("repulse_start_cnt", n_start, 4);
    run_op("mess", 3, '{16, 8, 4}, '{1, 2, 3}, '{7, 5, 2}, '{3, 1, 0}, 0, 0, 1, -1, 0);
    cfg2();

    run_op("abort", 3, '{16, 8, 4}, '{1, 2, 3}, '{7, 5, 2}, '{3, 1, 0}, 0, 0, 0, 1, 3);
    chk("abort_pre_idx", idx, 1);
    #2 rstn = 1'b0; op_en = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_idx", idx, 0);
    chk("abort_pos", pos, 0);
    chk("abort_widths", {s_inw, s_outw}, 0);
    chk("abort_done", done, 0);
`ifdef NVDLA_PDP_SPLIT_SCHED_PERF_EN
    chk("abort_stall", stall_cnt, 0);
`endif
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", n_done, 5);
    run_op("after", 3, '{16, 8, 4}, '{1, 2, 3}, '{7, 5, 2}, '{3, 1, 0}, 0, 0, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
